mha_score_engine: RTL

- Multi-head scaled dot-product score engine, integer fixed-point; replaces the behavioural score loop of the encoder block with a sequential single-MAC datapath.
- Holds SEQ x EMB Q and K matrices loaded row-by-row, computes S[h][i][j] = (Q_i,h · K_j,h) >>> SCALE_SH per head, saturates, and streams scores out over a valid/ready handshake.
- New behaviour: optional causal masking, per-row running max sideband for the downstream softmax, sticky saturation flag, output backpressure.

---
 rtl/mha_score_engine_if.sv | 44 ++++
 rtl/mha_score_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mha_score_engine_if.sv
// Row-load, control and score-stream signals of mha_score_engine.
// The engine attaches through the slave modport; the driving side uses master.
interface mha_score_engine_if #(
  parameter int SEQ     = 4,
  parameter int EMB     = 8,
  parameter int HEADS   = 2,
  parameter int DATA_W  = 16,
  parameter int SCORE_W = 32
);
  localparam int ROW_W  = (SEQ > 1) ? $clog2(SEQ) : 1;
  localparam int HEAD_W = (HEADS > 1) ? $clog2(HEADS) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sel;
  logic [ROW_W-1:0]        in_row;
  logic [EMB*DATA_W-1:0]   in_data;
  logic                    start;
  logic                    mask_en;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  logic [SCORE_W-1:0]      out_data;
  logic [HEAD_W-1:0]       out_head;
  logic [ROW_W-1:0]        out_row;
  logic [ROW_W-1:0]        out_col;
  logic                    out_row_last;
  logic [SCORE_W-1:0]      out_row_max;
  logic                    out_last;
  logic                    done;
  logic                    sat;

  modport master (
    output in_valid, in_sel, in_row, in_data, start, mask_en, out_ready,
    input  in_ready, busy, out_valid, out_data, out_head, out_row, out_col,
           out_row_last, out_row_max, out_last, done, sat
  );

  modport slave (
    input  in_valid, in_sel, in_row, in_data, start, mask_en, out_ready,
    output in_ready, busy, out_valid, out_data, out_head, out_row, out_col,
           out_row_last, out_row_max, out_last, done, sat
  );
endinterface

// File: rtl/mha_score_engine.sv
// Multi-head scaled dot-product score engine: one signed MAC per cycle over
// per-head slices of stored Q/K rows, with shift, saturation and causal mask.
module mha_score_engine #(
  parameter int SEQ      = 4,
  parameter int EMB      = 8,
  parameter int HEADS    = 2,
  parameter int HEAD_DIM = EMB / HEADS,
  parameter int DATA_W   = 16,
  parameter int SCORE_W  = 32,
  parameter int SCALE_SH = 1
) (
  input  logic              clk,
  input  logic              rst,
  mha_score_engine_if.slave bus
);

  localparam int ROW_W  = (SEQ > 1) ? $clog2(SEQ) : 1;
  localparam int HEAD_W = (HEADS > 1) ? $clog2(HEADS) : 1;
  localparam int DIM_W  = (HEAD_DIM > 1) ? $clog2(HEAD_DIM) : 1;
  localparam int EMB_W  = (EMB > 1) ? $clog2(EMB) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + $clog2(HEAD_DIM);
  localparam int WIDE_W = ((ACC_W > SCORE_W) ? ACC_W : SCORE_W) + 1;

  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic signed [SCORE_W-1:0] SCORE_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0]  WIDE_MIN  = WIDE_W'(SCORE_MIN);
  localparam logic signed [WIDE_W-1:0]  WIDE_MAX  = WIDE_W'(SCORE_MAX);

  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(SEQ - 1);
  localparam logic [HEAD_W-1:0] LAST_HEAD = HEAD_W'(HEADS - 1);
  localparam logic [DIM_W-1:0]  LAST_DIM  = DIM_W'(HEAD_DIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_FINISH} state_e;

  state_e                     state_q, state_d;
  logic [HEAD_W-1:0]          head_q, head_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [ROW_W-1:0]           col_q, col_d;
  logic [DIM_W-1:0]           dim_q, dim_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       mask_q, mask_d;
  logic signed [SCORE_W-1:0]  out_data_q, out_data_d;
  logic signed [SCORE_W-1:0]  row_max_q, row_max_d;
  logic                       sat_q, sat_d;

  logic signed [DATA_W-1:0]   q_mem [SEQ][EMB];
  logic signed [DATA_W-1:0]   k_mem [SEQ][EMB];

  logic                       load_fire;
  logic [EMB_W-1:0]           elem_idx;
  logic signed [DATA_W-1:0]   q_elem;
  logic signed [DATA_W-1:0]   k_elem;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    acc_base;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [WIDE_W-1:0]   acc_wide;
  logic signed [WIDE_W-1:0]   shifted;
  logic signed [SCORE_W-1:0]  score;
  logic                       ovf;
  logic                       masked;

  assign load_fire = bus.in_valid && (state_q == S_IDLE);

  // NOTE: Q/K storage has no reset; rows are loaded before use and must survive a mid-pass reset.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      for (int d = 0; d < EMB; d++) begin
        if (bus.in_sel) k_mem[bus.in_row][d] <= bus.in_data[d*DATA_W +: DATA_W];
        else            q_mem[bus.in_row][d] <= bus.in_data[d*DATA_W +: DATA_W];
      end
    end
  end

  // Datapath: one product of the current head slice, accumulate, floor-shift, saturate.
  always_comb begin
    elem_idx = EMB_W'(head_q) * EMB_W'(HEAD_DIM) + EMB_W'(dim_q);
    q_elem   = q_mem[row_q][elem_idx];
    k_elem   = k_mem[col_q][elem_idx];
    prod     = PROD_W'(q_elem) * PROD_W'(k_elem);
    acc_base = (dim_q == '0) ? '0 : acc_q;
    acc_sum  = acc_base + ACC_W'(prod);
    acc_wide = WIDE_W'(acc_sum);
    shifted  = acc_wide >>> SCALE_SH;
    score    = shifted[SCORE_W-1:0];
    ovf      = 1'b0;
    if (shifted > WIDE_MAX) begin
      score = SCORE_MAX;
      ovf   = 1'b1;
    end else if (shifted < WIDE_MIN) begin
      score = SCORE_MIN;
      ovf   = 1'b1;
    end
    masked = mask_q && (col_q > row_q);
  end

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through this block can infer a latch.
    state_d    = state_q;
    head_d     = head_q;
    row_d      = row_q;
    col_d      = col_q;
    dim_d      = dim_q;
    acc_d      = acc_q;
    mask_d     = mask_q;
    out_data_d = out_data_q;
    row_max_d  = row_max_q;
    sat_d      = sat_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_MAC;
          head_d  = '0;
          row_d   = '0;
          col_d   = '0;
          dim_d   = '0;
          mask_d  = bus.mask_en;
          sat_d   = 1'b0;
        end
      end

      S_MAC: begin
        if (masked) begin
          out_data_d = SCORE_MIN;
          if (col_q == '0) row_max_d = SCORE_MIN;
          state_d = S_EMIT;
        end else if (dim_q == LAST_DIM) begin
          out_data_d = score;
          sat_d      = sat_q | ovf;
          if ((col_q == '0) || (score > row_max_q)) row_max_d = score;
          dim_d   = '0;
          state_d = S_EMIT;
        end else begin
          acc_d = acc_sum;
          dim_d = dim_q + DIM_W'(1);
        end
      end

      // Coordinates advance only on a handshake, so out_* hold during backpressure.
      S_EMIT: begin
        if (bus.out_ready) begin
          dim_d = '0;
          if (col_q != LAST_ROW) begin
            col_d   = col_q + ROW_W'(1);
            state_d = S_MAC;
          end else if (row_q != LAST_ROW) begin
            col_d   = '0;
            row_d   = row_q + ROW_W'(1);
            state_d = S_MAC;
          end else if (head_q != LAST_HEAD) begin
            col_d   = '0;
            row_d   = '0;
            head_d  = head_q + HEAD_W'(1);
            state_d = S_MAC;
          end else begin
            state_d = S_FINISH;
          end
        end
      end

      S_FINISH: state_d = S_IDLE;

      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use <= so every _q in the design reads its pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      dim_q      <= '0;
      acc_q      <= '0;
      mask_q     <= 1'b0;
      out_data_q <= '0;
      row_max_q  <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      row_q      <= row_d;
      col_q      <= col_d;
      dim_q      <= dim_d;
      acc_q      <= acc_d;
      mask_q     <= mask_d;
      out_data_q <= out_data_d;
      row_max_q  <= row_max_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.out_valid    = (state_q == S_EMIT);
  assign bus.out_data     = out_data_q;
  assign bus.out_head     = head_q;
  assign bus.out_row      = row_q;
  assign bus.out_col      = col_q;
  assign bus.out_row_last = (state_q == S_EMIT) && (col_q == LAST_ROW);
  assign bus.out_row_max  = row_max_q;
  assign bus.out_last     = (state_q == S_EMIT) && (col_q == LAST_ROW) &&
                            (row_q == LAST_ROW) && (head_q == LAST_HEAD);
  assign bus.done         = (state_q == S_FINISH);
  assign bus.sat          = sat_q;

endmodule
